sprite_fetch_arbiter: RTL and testbench

SPRITE_FETCH_ARBITER -- requirements
Module: sprite_fetch_arbiter

---
 rtl/sprite_fetch_arbiter_pkg.sv | 33 +++
 rtl/sprite_fetch_arbiter_age_prio_sel.sv | 39 +++
 rtl/sprite_fetch_arbiter.sv | 150 +++++++++++++++
 tb/tb_sprite_fetch_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_fetch_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Shared constants for the sprite fetch arbiter: requester
//               index map, default bus widths and the sprite transparency key.
// Revision    : 1.0  initial release
// ============================================================================
package sprite_pkg;

    // Requester index map (priority order, 0 = highest)
    localparam int END_IDX   = 0;
    localparam int PEA_IDX   = 1;
    localparam int ZOM_IDX   = 2;
    localparam int COORD_IDX = 3;
    localparam int PLANT_IDX = 4;

    localparam int N_REQ  = 5;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 24;

    // RGB value treated as transparent by downstream sprite compositing
    localparam logic [23:0] TRANSP_KEY = 24'h800080;

    typedef enum logic [2:0] {
        REQ_END   = 3'd0,
        REQ_PEA   = 3'd1,
        REQ_ZOM   = 3'd2,
        REQ_COORD = 3'd3,
        REQ_PLANT = 3'd4
    } req_idx_e;

endpackage : sprite_pkg
`default_nettype wire

// File: rtl/sprite_fetch_arbiter_age_prio_sel.sv
`default_nettype none
// ============================================================================
// Module      : age_prio_sel
// Description : Combinational grant selector. Requesters that are asserted
//               and not masked are eligible; if any eligible requester has
//               its age-saturated flag set, only those compete. The lowest
//               index among the competitors wins.
// Ports       : i_req  [N_REQ] request vector
//               i_sat  [N_REQ] age-saturated flags
//               i_mask [N_REQ] requesters excluded this cycle
//               o_gnt  [N_REQ] one-hot (or zero) selection
// Revision    : 1.0  initial release
// ============================================================================
module age_prio_sel
    import sprite_pkg::*;
#(
    parameter int N_REQ = sprite_pkg::N_REQ
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_sat,
    input  logic [N_REQ-1:0] i_mask,
    output logic [N_REQ-1:0] o_gnt
);

    localparam logic [N_REQ-1:0] C_ONE = 1;

    logic [N_REQ-1:0] w_pend;
    logic [N_REQ-1:0] w_boost;
    logic [N_REQ-1:0] w_cand;

    assign w_pend  = i_req & ~i_mask;
    assign w_boost = w_pend & i_sat;
    assign w_cand  = (|w_boost) ? w_boost : w_pend;

    // Two's-complement trick isolates the lowest set bit
    assign o_gnt   = w_cand & (~w_cand + C_ONE);

endmodule : age_prio_sel
`default_nettype wire

// File: rtl/sprite_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_fetch_arbiter
// Description : Arbitrates sprite-layer ROM reads between N_REQ requesters.
//               Fixed low-index priority with age boosting, one read per
//               cycle, and a tag pipeline that routes each returned ROM word
//               back to its requester ROM_LAT+1 cycles after the grant.
// Ports       : i_clk        system clock (rising edge)
//               i_rst_n      synchronous active-low reset
//               i_req        per-requester read request
//               i_req_addr   flattened request addresses, slice i*ADDR_W
//               o_gnt        registered one-hot grant
//               o_rom_rd     registered ROM read strobe
//               o_rom_addr   registered ROM address
//               i_rom_q      ROM data, valid ROM_LAT cycles after o_rom_rd
//               o_rdata      returned RGB word
//               o_rvalid     one-hot owner of o_rdata
// Revision    : 1.0  initial release
// ============================================================================
module sprite_fetch_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ   = sprite_pkg::N_REQ,
    parameter int ADDR_W  = sprite_pkg::ADDR_W,
    parameter int DATA_W  = sprite_pkg::DATA_W,
    parameter int ROM_LAT = 2,
    parameter int AGE_MAX = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*ADDR_W-1:0]   i_req_addr,
    output logic [N_REQ-1:0]          o_gnt,
    output logic                      o_rom_rd,
    output logic [ADDR_W-1:0]         o_rom_addr,
    input  logic [DATA_W-1:0]         i_rom_q,
    output logic [DATA_W-1:0]         o_rdata,
    output logic [N_REQ-1:0]          o_rvalid
);

    localparam int               AGE_W     = $clog2(AGE_MAX + 1);
    localparam logic [AGE_W-1:0] C_AGE_MAX = AGE_W'(AGE_MAX);
    localparam logic [AGE_W-1:0] C_AGE_ONE = 1;

    logic [N_REQ-1:0]             w_sat;
    logic [N_REQ-1:0]             w_sel;
    logic [ADDR_W-1:0]            w_sel_addr;

    logic [N_REQ-1:0][AGE_W-1:0]  r_age;
    logic [N_REQ-1:0]             r_gnt;
    logic                         r_rom_rd;
    logic [ADDR_W-1:0]            r_rom_addr;
    logic [DATA_W-1:0]            r_rdata;
    // r_tag[k] holds the grant issued k+1 edges earlier
    logic [N_REQ-1:0]             r_tag [ROM_LAT+1];

    // ------------------------------------------------------------------
    // Age tracking
    // ------------------------------------------------------------------
    always_comb begin
        w_sat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sat[i] = (r_age[i] >= C_AGE_MAX);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_age <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!i_req[i] || w_sel[i]) begin
                    r_age[i] <= '0;
                end else if (!w_sat[i]) begin
                    r_age[i] <= r_age[i] + C_AGE_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Selection: the index shown on o_gnt this cycle is masked so the
    // requester has time to drop or refresh its request.
    // ------------------------------------------------------------------
    age_prio_sel #(
        .N_REQ (N_REQ)
    ) u_sel (
        .i_req  (i_req),
        .i_sat  (w_sat),
        .i_mask (r_gnt),
        .o_gnt  (w_sel)
    );

    // One-hot select, so an OR-reduction mux is sufficient
    always_comb begin
        w_sel_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel[i]) begin
                w_sel_addr = w_sel_addr | i_req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant / ROM request registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_gnt      <= '0;
            r_rom_rd   <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            r_gnt    <= w_sel;
            r_rom_rd <= |w_sel;
            if (|w_sel) begin
                r_rom_addr <= w_sel_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Return path: tag pipeline plus data capture. Data is captured only
    // on the edge where a tag leaves the pipeline, so o_rdata holds the
    // last returned word in between.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k <= ROM_LAT; k++) begin
                r_tag[k] <= '0;
            end
            r_rdata <= '0;
        end else begin
            r_tag[0] <= r_gnt;
            for (int k = 1; k <= ROM_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
            if (|r_tag[ROM_LAT-1]) begin
                r_rdata <= i_rom_q;
            end
        end
    end

    assign o_gnt      = r_gnt;
    assign o_rom_rd   = r_rom_rd;
    assign o_rom_addr = r_rom_addr;
    assign o_rdata    = r_rdata;
    assign o_rvalid   = r_tag[ROM_LAT];

endmodule : sprite_fetch_arbiter
`default_nettype wire

// File: tb/tb_sprite_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_fetch_arbiter
// Description : Directed, table-driven bench for sprite_fetch_arbiter with a
//               fixed-latency ROM model and a return-path checker.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sprite_fetch_arbiter;

    localparam int N_REQ   = 5;
    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 24;
    localparam int ROM_LAT = 2;
    localparam int AGE_MAX = 8;
    localparam int L       = ROM_LAT + 1;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*ADDR_W-1:0]  req_addr;
    logic [N_REQ-1:0]         gnt;
    logic                     rom_rd;
    logic [ADDR_W-1:0]        rom_addr;
    logic [DATA_W-1:0]        rom_q;
    logic [DATA_W-1:0]        rdata;
    logic [N_REQ-1:0]         rvalid;

    always #5 clk = ~clk;

    sprite_fetch_arbiter #(
        .N_REQ   (N_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ROM_LAT (ROM_LAT),
        .AGE_MAX (AGE_MAX)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_req_addr (req_addr),
        .o_gnt      (gnt),
        .o_rom_rd   (rom_rd),
        .o_rom_addr (rom_addr),
        .i_rom_q    (rom_q),
        .o_rdata    (rdata),
        .o_rvalid   (rvalid)
    );

    // ROM model: data derived from address, ROM_LAT cycles after the read
    function automatic logic [DATA_W-1:0] romf(input logic [ADDR_W-1:0] a);
        return {5'd0, a} ^ 24'h5A3C96;
    endfunction

    logic [DATA_W-1:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= romf(rom_addr);
        for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign rom_q = rom_pipe[ROM_LAT-1];

    logic [ADDR_W-1:0] addr_tab [N_REQ];

    int checks = 0;
    int errors = 0;

    logic [N_REQ-1:0]  e_gnt  = '0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic              mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: present req, then check the registered grant outputs
    task automatic step(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] exp, input string name);
        req = r;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) if (exp[i]) e_addr = addr_tab[i];
        e_gnt = exp;
        check({name, ".gnt"},    {27'd0, gnt},        {27'd0, exp});
        check({name, ".rom_rd"}, {31'd0, rom_rd},     {31'd0, |exp});
        check({name, ".addr"},   {13'd0, rom_addr},   {13'd0, e_addr});
    endtask

    task automatic do_reset(input int cycles, input string name);
        rst_n = 1'b0;
        req   = '0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        e_gnt  = '0;
        e_addr = '0;
        check({name, ".gnt"},    {27'd0, gnt},      32'd0);
        check({name, ".rom_rd"}, {31'd0, rom_rd},   32'd0);
        check({name, ".addr"},   {13'd0, rom_addr}, 32'd0);
        check({name, ".rdata"},  {8'd0, rdata},     32'd0);
        check({name, ".rvalid"}, {27'd0, rvalid},   32'd0);
    endtask

    // Return-path checker: expected rvalid/rdata is the expected grant
    // history delayed by ROM_LAT+1 cycles; reset empties the history.
    logic [N_REQ-1:0]  h_gnt  [L];
    logic [ADDR_W-1:0] h_addr [L];
    initial begin
        for (int k = 0; k < L; k++) begin
            h_gnt[k]  = '0;
            h_addr[k] = '0;
        end
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("rvalid", {27'd0, rvalid}, {27'd0, h_gnt[L-1]});
                if (h_gnt[L-1] != '0)
                    check("rdata", {8'd0, rdata}, {8'd0, romf(h_addr[L-1])});
            end
            for (int k = L-1; k > 0; k--) begin
                h_gnt[k]  = h_gnt[k-1];
                h_addr[k] = h_addr[k-1];
            end
            if (!rst_n) begin
                for (int k = 0; k < L; k++) h_gnt[k] = '0;
            end else begin
                h_gnt[0]  = e_gnt;
                h_addr[0] = e_addr;
            end
        end
    end

    typedef struct {
        logic [N_REQ-1:0] r;
        logic [N_REQ-1:0] exp;
    } vec_t;

    vec_t vt [12];
    int   fair_seq [20];

    initial begin
        addr_tab[0] = 19'h1A000;
        addr_tab[1] = 19'h04321;
        addr_tab[2] = 19'h00100;
        addr_tab[3] = 19'h7FFFF;
        addr_tab[4] = 19'h2BEEF;
        for (int i = 0; i < N_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = addr_tab[i];

        // Single-cycle arbitration from an idle, zero-age state
        vt[0]  = '{5'b00001, 5'b00001};
        vt[1]  = '{5'b00010, 5'b00010};
        vt[2]  = '{5'b00100, 5'b00100};
        vt[3]  = '{5'b01000, 5'b01000};
        vt[4]  = '{5'b10000, 5'b10000};
        vt[5]  = '{5'b11111, 5'b00001};
        vt[6]  = '{5'b11110, 5'b00010};
        vt[7]  = '{5'b10100, 5'b00100};
        vt[8]  = '{5'b11000, 5'b01000};
        vt[9]  = '{5'b00000, 5'b00000};
        vt[10] = '{5'b10001, 5'b00001};
        vt[11] = '{5'b01010, 5'b00010};

        // All requesters held: 0/1 alternate until 2..4 reach age 8
        fair_seq = '{0,1,0,1,0,1,0,1,2,3,4,0,1,0,1,0,1,2,3,4};

        // Reset state
        do_reset(3, "reset");
        mon_en = 1'b1;

        // Single requester, first grant right after reset release
        step(5'b00100, 5'b00100, "single");
        repeat (L + 2) step(5'b00000, 5'b00000, "single_idle");

        for (int v = 0; v < 12; v++) begin
            step(vt[v].r, vt[v].exp, $sformatf("vec%0d", v));
            step(5'b00000, 5'b00000, $sformatf("vec%0d_idle", v));
        end
        repeat (L) step(5'b00000, 5'b00000, "vec_drain");

        // Age boosting with all requests held
        for (int k = 0; k < 20; k++) begin
            logic [N_REQ-1:0] oh;
            oh = '0;
            oh[fair_seq[k]] = 1'b1;
            step(5'b11111, oh, $sformatf("fair%0d", k));
        end
        repeat (L + 1) step(5'b00000, 5'b00000, "fair_idle");

        // Back-to-back reads alternating between 0 and 4
        for (int k = 0; k < 10; k++)
            step(5'b10001, (k % 2 == 0) ? 5'b00001 : 5'b10000, $sformatf("b2b%0d", k));
        repeat (L + 1) step(5'b00000, 5'b00000, "b2b_idle");

        // Short pulse on req[3] lost to req[0]
        step(5'b01001, 5'b00001, "pulse0");
        step(5'b00001, 5'b00000, "pulse1");
        step(5'b00001, 5'b00001, "pulse2");
        repeat (L + 1) step(5'b00000, 5'b00000, "pulse_idle");

        // Reset with two reads in flight
        step(5'b00011, 5'b00001, "inflight0");
        step(5'b00011, 5'b00010, "inflight1");
        do_reset(1, "midreset");
        repeat (4) step(5'b00000, 5'b00000, "post_reset");

        // Normal operation resumes after reset
        step(5'b01000, 5'b01000, "resume");
        repeat (L + 1) step(5'b00000, 5'b00000, "resume_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sprite_fetch_arbiter
`default_nettype wire
